// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational program ROM once per
// cycle and buffers {instr, pc} pairs in a 2-entry queue with branch-redirect flush.
module fetch_unit #(
    parameter int                 D_ANCHO  = 32,
    parameter int                 A_ANCHO  = 10,
    parameter logic [A_ANCHO-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    output logic [A_ANCHO-1:0] ROM_ADDR,
    input  logic [D_ANCHO-1:0] ROM_DOUT,
    input  logic               BR_VALID,
    input  logic [A_ANCHO-1:0] BR_TARGET,
    output logic [D_ANCHO-1:0] INSTR,
    output logic [A_ANCHO-1:0] INSTR_PC,
    output logic               INSTR_VALID,
    input  logic               INSTR_READY,
    output logic [1:0]         DBG_MODE
);

    // Queue occupancy doubles as the mode state: EMPTY=0, PART=1, FULL=2 entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [A_ANCHO-1:0] pc_q, pc_d;
    logic [D_ANCHO-1:0] instr_q [2];
    logic [D_ANCHO-1:0] instr_d [2];
    logic [A_ANCHO-1:0] ipc_q   [2];
    logic [A_ANCHO-1:0] ipc_d   [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               pop;
    logic               push;

    // Handshake: an entry transfers on a rising edge where INSTR_VALID and INSTR_READY
    // are both high; INSTR/INSTR_PC hold steady while INSTR_VALID is high and READY is low.
    always_comb begin
        pop  = (mode_q != EMPTY) && INSTR_READY;
        push = EN && !BR_VALID && ((mode_q != FULL) || pop);

        mode_d     = mode_q;
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        instr_d[0] = instr_q[0];
        instr_d[1] = instr_q[1];
        ipc_d[0]   = ipc_q[0];
        ipc_d[1]   = ipc_q[1];

        if (BR_VALID) begin
            // A pop in this cycle is still consumed; everything left behind is discarded.
            pc_d     = BR_TARGET;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            mode_d   = EMPTY;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = ROM_DOUT;
                ipc_d[wr_ptr_q]   = pc_q;
                wr_ptr_d          = ~wr_ptr_q;
                pc_d              = pc_q + A_ANCHO'(1);
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                if (mode_q == EMPTY) begin
                    mode_d = PART;
                end else begin
                    mode_d = FULL;
                end
            end else if (pop && !push) begin
                if (mode_q == FULL) begin
                    mode_d = PART;
                end else begin
                    mode_d = EMPTY;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q     <= EMPTY;
            pc_q       <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            ipc_q[0]   <= '0;
            ipc_q[1]   <= '0;
        end else begin
            mode_q     <= mode_d;
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            instr_q[0] <= instr_d[0];
            instr_q[1] <= instr_d[1];
            ipc_q[0]   <= ipc_d[0];
            ipc_q[1]   <= ipc_d[1];
        end
    end

    // ROM address comes straight from the PC flop so it only moves on edges or reset.
    assign ROM_ADDR    = pc_q;
    assign INSTR       = instr_q[rd_ptr_q];
    assign INSTR_PC    = ipc_q[rd_ptr_q];
    assign INSTR_VALID = (mode_q != EMPTY);
    assign DBG_MODE    = mode_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM with ROM[a] = a + 0x100, directed phases that
// queue expected {pc, instr} handshakes, and a negedge monitor that retires them.
module tb_fetch_unit;

    localparam int D_ANCHO = 32;
    localparam int A_ANCHO = 10;
    localparam int W       = A_ANCHO + D_ANCHO;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [A_ANCHO-1:0] rom_addr;
    logic [D_ANCHO-1:0] rom_dout;
    logic               br_valid;
    logic [A_ANCHO-1:0] br_target;
    logic [D_ANCHO-1:0] instr;
    logic [A_ANCHO-1:0] instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [1:0]         dbg_mode;

    logic [W-1:0] exp_q[$];
    int           tests_run = 0;
    int           tests_failed = 0;
    int           hs_count = 0;
    int           hs_mark;

    fetch_unit #(
        .D_ANCHO (D_ANCHO),
        .A_ANCHO (A_ANCHO),
        .RESET_PC('0)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .EN         (en),
        .ROM_ADDR   (rom_addr),
        .ROM_DOUT   (rom_dout),
        .BR_VALID   (br_valid),
        .BR_TARGET  (br_target),
        .INSTR      (instr),
        .INSTR_PC   (instr_pc),
        .INSTR_VALID(instr_valid),
        .INSTR_READY(instr_ready),
        .DBG_MODE   (dbg_mode)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [D_ANCHO-1:0] rom_word(input logic [A_ANCHO-1:0] a);
        return D_ANCHO'(a) + 32'h100;
    endfunction

    always_comb rom_dout = rom_word(rom_addr);

    // driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_pc(input logic [A_ANCHO-1:0] pc);
        exp_q.push_back({pc, rom_word(pc)});
    endtask

    // Called between edges; releases reset well before the next rising edge.
    task automatic do_reset();
        en       = 1'b0;
        br_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // scoreboard monitor: a handshake completes on the next rising edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && instr_valid && instr_ready) begin
            hs_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_handshake: got pc=%0h instr=%0h, expected none",
                         instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    tests_failed++;
                    $display("FAIL handshake: got pc=%0h instr=%0h, expected pc=%0h instr=%0h",
                             instr_pc, instr, e[W-1:D_ANCHO], e[D_ANCHO-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        en          = 1'b0;
        br_valid    = 1'b0;
        br_target   = '0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("reset_rom_addr", 64'(rom_addr), 64'h0);
        check("reset_valid", 64'(instr_valid), 64'd0);
        check("reset_instr", 64'(instr), 64'h0);
        check("reset_instr_pc", 64'(instr_pc), 64'h0);
        check("reset_mode", 64'(dbg_mode), 64'd0);
        #2;
        rst_n = 1'b1;

        // sequential fetch, one per cycle
        for (int i = 0; i < 8; i++) expect_pc(A_ANCHO'(i));
        en = 1'b1;
        instr_ready = 1'b1;
        tick(1);
        check("seq_first_valid", 64'(instr_valid), 64'd1);
        check("seq_first_pc", 64'(instr_pc), 64'h0);
        check("seq_first_instr", 64'(instr), 64'h100);
        tick(7);
        en = 1'b0;
        tick(3);
        check("seq_pc_frozen", 64'(rom_addr), 64'h8);
        check("seq_drained_valid", 64'(instr_valid), 64'd0);
        check_drained("seq");

        // backpressure: queue fills in two edges, then PC holds
        do_reset();
        instr_ready = 1'b0;
        en = 1'b1;
        tick(1);
        check("bp_mode_part", 64'(dbg_mode), 64'd1);
        tick(4);
        check("bp_rom_addr", 64'(rom_addr), 64'h2);
        check("bp_mode_full", 64'(dbg_mode), 64'd2);
        check("bp_head_pc", 64'(instr_pc), 64'h0);
        for (int i = 0; i < 6; i++) expect_pc(A_ANCHO'(i));
        instr_ready = 1'b1;
        tick(4);
        en = 1'b0;
        tick(3);
        check("bp_pc_frozen", 64'(rom_addr), 64'h6);
        check_drained("bp");

        // redirect while head is pc 3
        do_reset();
        for (int i = 0; i < 4; i++) expect_pc(A_ANCHO'(i));
        expect_pc(10'h200);
        expect_pc(10'h201);
        instr_ready = 1'b1;
        en = 1'b1;
        tick(4);
        check("br_head_pc3", 64'(instr_pc), 64'h3);
        br_valid  = 1'b1;
        br_target = 10'h200;
        tick(1);
        br_valid = 1'b0;
        check("br_bubble_valid", 64'(instr_valid), 64'd0);
        check("br_rom_addr", 64'(rom_addr), 64'h200);
        tick(1);
        check("br_target_pc", 64'(instr_pc), 64'h200);
        check("br_target_instr", 64'(instr), 64'h300);
        tick(1);
        en = 1'b0;
        tick(2);
        check_drained("br");

        // redirect at FULL with a simultaneous pop and EN low
        do_reset();
        instr_ready = 1'b0;
        en = 1'b1;
        tick(2);
        check("brf_full", 64'(dbg_mode), 64'd2);
        expect_pc(10'h0);
        hs_mark     = hs_count;
        en          = 1'b0;
        instr_ready = 1'b1;
        br_valid    = 1'b1;
        br_target   = 10'h050;
        tick(1);
        br_valid = 1'b0;
        check("brf_empty_valid", 64'(instr_valid), 64'd0);
        check("brf_rom_addr", 64'(rom_addr), 64'h050);
        tick(3);
        check("brf_one_handshake", 64'(hs_count - hs_mark), 64'd1);
        check("brf_no_push_valid", 64'(instr_valid), 64'd0);
        check("brf_pc_held", 64'(rom_addr), 64'h050);
        expect_pc(10'h050);
        expect_pc(10'h051);
        en = 1'b1;
        tick(1);
        check("brf_target_pc", 64'(instr_pc), 64'h050);
        tick(1);
        en = 1'b0;
        tick(2);
        check_drained("brf");

        // address wrap-around
        do_reset();
        instr_ready = 1'b1;
        en          = 1'b1;
        br_valid    = 1'b1;
        br_target   = 10'h3FE;
        expect_pc(10'h3FE);
        expect_pc(10'h3FF);
        expect_pc(10'h000);
        expect_pc(10'h001);
        tick(1);
        br_valid = 1'b0;
        check("wrap_bubble_valid", 64'(instr_valid), 64'd0);
        tick(4);
        en = 1'b0;
        tick(2);
        check("wrap_rom_addr", 64'(rom_addr), 64'h2);
        check_drained("wrap");

        // asynchronous reset while FULL
        do_reset();
        instr_ready = 1'b0;
        en = 1'b1;
        tick(2);
        check("areset_pre_full", 64'(dbg_mode), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(instr_valid), 64'd0);
        check("areset_rom_addr", 64'(rom_addr), 64'h0);
        check("areset_instr", 64'(instr), 64'h0);
        check("areset_instr_pc", 64'(instr_pc), 64'h0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) expect_pc(A_ANCHO'(i));
        instr_ready = 1'b1;
        tick(1);
        check("areset_restart_pc", 64'(instr_pc), 64'h0);
        check("areset_restart_instr", 64'(instr), 64'h100);
        tick(2);
        en = 1'b0;
        tick(2);
        check_drained("areset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
